// File: rtl/sram_like_if.sv
// SRAM-like request/response bus between a CPU-side requester and a memory-side responder.
// req/addr_ok is the request handshake; data_ok/rdata is the in-order response channel.
interface sram_like_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        hold;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata, hold,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata, hold,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_like_responder.sv
// Memory-side responder for the SRAM-like bus: word store with byte strobes and
// an in-order return queue that answers each accepted request LATENCY cycles later.
module sram_like_responder #(
    parameter int unsigned MEM_AW  = 12,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned DEPTH   = 4
) (
    input  logic        clk,
    input  logic        resetn,
    sram_like_if.slave  bus
);

    localparam int unsigned WORDS = 1 << MEM_AW;
    localparam int unsigned AGE_W = $clog2(LATENCY + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic              is_read;
        logic [31:0]       data;
        logic [AGE_W-1:0]  age;
    } entry_t;

    entry_t            fifo [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [31:0]       mem [WORDS];

    logic [MEM_AW-1:0] idx_c;
    entry_t            head_c;
    logic              full_c;
    logic              accept_c;
    logic              retire_c;
    logic              addr_ok_c;
    logic              data_ok_c;
    logic [31:0]       rdata_c;
    logic              unused_c;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Width and transfer size are informational only; strobes decide what is written.
    assign unused_c = ^{bus.size, bus.addr};

    // Response and acceptance decode from queue state and the current inputs.
    always_comb begin
        idx_c     = bus.addr[MEM_AW+1:2];
        head_c    = fifo[rd_ptr];
        full_c    = (count == CNT_W'(DEPTH));
        data_ok_c = resetn && (count != '0) && (head_c.age == AGE_W'(LATENCY));
        rdata_c   = '0;
        if (data_ok_c && head_c.is_read) begin
            rdata_c = head_c.data;
        end
        // A retiring head frees its slot in time for a same-cycle accept.
        addr_ok_c = resetn && !bus.hold && (!full_c || data_ok_c);
        accept_c  = bus.req && addr_ok_c;
        retire_c  = data_ok_c;
    end

    assign bus.addr_ok = addr_ok_c;
    assign bus.data_ok = data_ok_c;
    assign bus.rdata   = rdata_c;

    // Return queue; entries start at age 1 because the acceptance edge counts as the first.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (fifo[i].age != AGE_W'(LATENCY)) begin
                    fifo[i].age <= fifo[i].age + AGE_W'(1);
                end
            end
            if (accept_c) begin
                fifo[wr_ptr].is_read <= !bus.wr;
                fifo[wr_ptr].data    <= bus.wr ? 32'h0 : mem[idx_c];
                fifo[wr_ptr].age     <= AGE_W'(1);
                wr_ptr               <= ptr_next(wr_ptr);
            end
            if (retire_c) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({accept_c, retire_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Backing store keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (accept_c && bus.wr) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.wstrb[b]) begin
                    mem[idx_c][8*b +: 8] <= bus.wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_like_responder.sv
// Bench for sram_like_responder: two instances (LATENCY 2/DEPTH 4 and LATENCY 3/DEPTH 2)
// share stimulus and are compared each cycle against a due-cycle reference model.
module tb_sram_like_responder;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        hold;

    always #5 clk = ~clk;

    sram_like_if bus_a ();
    sram_like_if bus_b ();

    assign bus_a.req = req;   assign bus_b.req = req;
    assign bus_a.wr = wr;     assign bus_b.wr = wr;
    assign bus_a.size = size; assign bus_b.size = size;
    assign bus_a.wstrb = wstrb; assign bus_b.wstrb = wstrb;
    assign bus_a.addr = addr; assign bus_b.addr = addr;
    assign bus_a.wdata = wdata; assign bus_b.wdata = wdata;
    assign bus_a.hold = hold; assign bus_b.hold = hold;

    sram_like_responder #(.MEM_AW(12), .LATENCY(2), .DEPTH(4)) dut_a (
        .clk(clk), .resetn(resetn), .bus(bus_a.slave)
    );
    sram_like_responder #(.MEM_AW(12), .LATENCY(3), .DEPTH(2)) dut_b (
        .clk(clk), .resetn(resetn), .bus(bus_b.slave)
    );

    // Reference model: each accepted request becomes a response due at a fixed cycle number.
    typedef struct {
        int          due;
        logic        rd;
        logic [31:0] data;
    } resp_t;

    resp_t       q [2][16];
    int          head [2];
    int          cnt [2];
    logic [31:0] mem [2][4096];
    int          cyc;
    logic        acc_last [2];
    logic [31:0] last_rd [2];
    logic [31:0] seq_b [8];
    int          nseq_b;
    int          npass;
    int          nchk;

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : 3;
    endfunction

    function automatic int dep_of(input int i);
        return (i == 0) ? 4 : 2;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // One bus cycle: apply inputs, compare outputs mid-cycle, then advance the model past the edge.
    task automatic step(input logic rn, input logic rq, input logic w, input logic [3:0] sb,
                        input logic [31:0] a, input logic [31:0] wd, input logic h);
        logic        dok [2];
        logic        aok [2];
        logic [31:0] exp_rdata;
        logic [31:0] got_rdata;
        logic        got_aok;
        logic        got_dok;
        int          idx;
        int          slot;
        string       nm;
        resetn = rn; req = rq; wr = w; wstrb = sb; addr = a; wdata = wd; hold = h;
        size = 2'd2;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            nm        = (i == 0) ? "a" : "b";
            dok[i]    = rn && (cnt[i] > 0) && (q[i][head[i]].due == cyc);
            aok[i]    = rn && !h && ((cnt[i] < dep_of(i)) || dok[i]);
            exp_rdata = (dok[i] && q[i][head[i]].rd) ? q[i][head[i]].data : 32'h0;
            got_aok   = (i == 0) ? bus_a.addr_ok : bus_b.addr_ok;
            got_dok   = (i == 0) ? bus_a.data_ok : bus_b.data_ok;
            got_rdata = (i == 0) ? bus_a.rdata : bus_b.rdata;
            check({nm, "_addr_ok"}, 32'(got_aok), 32'(aok[i]));
            check({nm, "_data_ok"}, 32'(got_dok), 32'(dok[i]));
            check({nm, "_rdata"}, got_rdata, exp_rdata);
            if (dok[i] && q[i][head[i]].rd) begin
                last_rd[i] = got_rdata;
                if (i == 1 && nseq_b < 8) begin
                    seq_b[nseq_b] = got_rdata;
                    nseq_b++;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            acc_last[i] = rq && aok[i];
            if (!rn) begin
                cnt[i]  = 0;
                head[i] = 0;
            end else begin
                if (dok[i]) begin
                    head[i] = (head[i] + 1) % 16;
                    cnt[i]--;
                end
                if (rq && aok[i]) begin
                    idx = int'(a[13:2]);
                    if (w) begin
                        for (int b = 0; b < 4; b++)
                            if (sb[b]) mem[i][idx][8*b +: 8] = wd[8*b +: 8];
                    end
                    slot = (head[i] + cnt[i]) % 16;
                    q[i][slot].due  = cyc + lat_of(i);
                    q[i][slot].rd   = !w;
                    q[i][slot].data = w ? 32'h0 : mem[i][idx];
                    cnt[i]++;
                end
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic wr_word(input logic [31:0] a, input logic [31:0] d, input logic [3:0] sb);
        step(1'b1, 1'b1, 1'b1, sb, a, d, 1'b0);
    endtask

    task automatic rd_word(input logic [31:0] a);
        step(1'b1, 1'b1, 1'b0, 4'h0, a, 32'h0, 1'b0);
    endtask

    initial begin
        int k;
        int guard;
        npass = 0; nchk = 0; cyc = 0; nseq_b = 0;
        for (int i = 0; i < 2; i++) begin
            cnt[i] = 0; head[i] = 0; last_rd[i] = 32'hFFFF_FFFF; acc_last[i] = 1'b0;
        end
        resetn = 1'b0; req = 1'b0; wr = 1'b0; size = 2'd0; wstrb = 4'h0;
        addr = 32'h0; wdata = 32'h0; hold = 1'b0;
        @(posedge clk);
        #1;
        repeat (2) step(1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);

        // Preload words 0..15; words 0..3 hold 1..4.
        for (int w = 0; w < 16; w++) begin
            wr_word(32'(w * 4), (w < 4) ? 32'(w + 1) : $urandom, 4'hF);
            idle(3);
        end

        // Write then read-back on the next cycle.
        for (int i = 0; i < 2; i++) last_rd[i] = 32'hFFFF_FFFF;
        wr_word(32'h10, 32'h1234_5678, 4'hF);
        rd_word(32'h10);
        idle(5);
        check("t1_rd_a", last_rd[0], 32'h1234_5678);
        check("t1_rd_b", last_rd[1], 32'h1234_5678);

        // Partial-strobe merge, then low address bits ignored.
        wr_word(32'h20, 32'h1234_5678, 4'hF);
        idle(3);
        wr_word(32'h20, 32'h0000_AB00, 4'h2);
        idle(3);
        rd_word(32'h20);
        idle(5);
        check("t2_rmw_a", last_rd[0], 32'h1234_AB78);
        check("t2_rmw_b", last_rd[1], 32'h1234_AB78);
        for (int i = 0; i < 2; i++) last_rd[i] = 32'hFFFF_FFFF;
        rd_word(32'h23);
        idle(5);
        check("t2_lowbits_a", last_rd[0], 32'h1234_AB78);
        check("t2_lowbits_b", last_rd[1], 32'h1234_AB78);

        // req held high until the small instance takes each of four reads.
        nseq_b = 0; k = 0; guard = 0;
        while (k < 4 && guard < 40) begin
            rd_word(32'(k * 4));
            if (acc_last[1]) k++;
            guard++;
        end
        check("t3_issued", 32'(k), 32'd4);
        idle(6);
        check("t3_count", 32'(nseq_b), 32'd4);
        for (int j = 0; j < 4; j++) check($sformatf("t3_order%0d", j), seq_b[j], 32'(j + 1));

        // Back-pressure while responses are in flight.
        rd_word(32'h0);
        rd_word(32'h4);
        repeat (5) step(1'b1, 1'b1, 1'b0, 4'h0, 32'h8, 32'h0, 1'b1);
        rd_word(32'h8);
        idle(6);

        // Reset drops in-flight reads but keeps memory.
        rd_word(32'h0);
        rd_word(32'h4);
        for (int i = 0; i < 2; i++) last_rd[i] = 32'hFFFF_FFFF;
        step(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        idle(6);
        check("t5_dropped_a", last_rd[0], 32'hFFFF_FFFF);
        check("t5_dropped_b", last_rd[1], 32'hFFFF_FFFF);
        rd_word(32'h10);
        idle(5);
        check("t5_kept_a", last_rd[0], 32'h1234_5678);
        check("t5_kept_b", last_rd[1], 32'h1234_5678);

        // Bits above the store index alias.
        wr_word(32'h4000, 32'hDEAD_BEEF, 4'hF);
        idle(3);
        rd_word(32'h0);
        idle(5);
        check("t6_alias_a", last_rd[0], 32'hDEAD_BEEF);
        check("t6_alias_b", last_rd[1], 32'hDEAD_BEEF);

        // Random traffic over the preloaded words with aliased upper bits.
        repeat (1500) begin
            step(($urandom % 64) != 0, ($urandom % 4) != 0, 1'($urandom % 2), 4'($urandom),
                 ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom % 4),
                 $urandom, ($urandom % 8) == 0);
        end
        idle(8);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/sram_like_responder.md
Name: sram_like_responder

Overview:
- Memory-side responder for the CPU's SRAM-like request/response interface (req/addr_ok, data_ok/rdata). One instance serves the instruction port and one serves the data port.
- Accepts one request per cycle and completes every accepted transaction in order, a fixed LATENCY cycles after acceptance.
- Holds an internal word-organised backing store with byte write strobes.
- Serves as the SoC-side model and bench target for the next pipeline revision, where the data ports move from fixed-timing SRAM to handshake.

Parameters:
- MEM_AW, 12, log2 of backing-store depth in 32-bit words; word index is addr[MEM_AW+1:2].
- LATENCY, 2, cycles from the acceptance edge to data_ok; legal range is 1 or more.
- DEPTH, 4, maximum number of outstanding (accepted, not yet returned) transactions; legal range is 1 or more.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- resetn  in  1  reset, synchronous, active-low.
- req  in  1  request valid.
- wr  in  1  1 = write, 0 = read.
- size  in  2  0 = byte, 1 = half, 2 = word; recorded only; wstrb is authoritative for writes.
- wstrb  in  4  byte write enables, bit i controls wdata[8i+7:8i].
- addr  in  32  byte address; addr[1:0] and bits above MEM_AW+1 are ignored.
- wdata  in  32  write data.
- hold  in  1  test back-pressure; forces addr_ok low.
- addr_ok  out  1  request accepted this cycle when req & addr_ok.
- data_ok  out  1  one-cycle completion pulse, one per accepted transaction, in acceptance order.
- rdata  out  32  read data, valid only while data_ok is high for a read; 0 for writes.

Behaviour:
- Acceptance:
  - A transaction is accepted at a rising edge where resetn & req & addr_ok.
  - addr_ok = resetn & ~hold & (outstanding < DEPTH | data_ok); it is combinational from registered state and the two inputs.
  - Retiring a transaction frees its slot in the same cycle, so accept and retire can happen together when full.
- Write: at the acceptance edge, store[idx] byte i <= wdata byte i for each set wstrb[i]. wstrb = 0 is a legal no-op write that still produces data_ok.
- Read: the word store[idx] is sampled at the acceptance edge, after any write accepted at an earlier edge. A read therefore always sees all earlier-accepted writes.
- Return queue:
  - FIFO of DEPTH entries, each holding {is_read, data, age counter}. The age counter is clog2(LATENCY+1) bits and saturates.
  - data_ok is high in the cycle that starts LATENCY edges after the acceptance edge. With LATENCY = 1 this behaves like the sync SRAM: the response is in the next cycle.
  - The head entry pops at the end of its data_ok cycle.
  - There is no back-pressure on data_ok; the requester must consume it.
- Throughput: back-to-back requests produce back-to-back data_ok pulses. Sustained rate is min(1, DEPTH/LATENCY) transactions per cycle.
- Full: when outstanding == DEPTH and there is no retire this cycle, addr_ok = 0. req may stay high, and the request is taken on the first cycle a slot frees.
- Empty: data_ok = 0 and rdata = 0.
- Counters: outstanding increments on accept, decrements on retire, and is unchanged when both happen in the same cycle.
- hold: only blocks acceptance. Transactions already in flight still return on schedule.
- Reset values while resetn = 0 (sampled at the edge):
  - FIFO is cleared and outstanding = 0.
  - addr_ok = 0, data_ok = 0, rdata = 0.
  - In-flight transactions are dropped and never return.
  - Backing-store contents are retained and not reset.
- Address wrap: addresses differing only above bit MEM_AW+1 alias to the same word.

Test Plan:
- Write addr 0x10, wdata 0x12345678, wstrb 0xF, then read 0x10 on the next cycle, with LATENCY=2 → write data_ok at acceptance+2 with rdata 0; read data_ok one cycle later with rdata 0x12345678.
- Word at 0x20 holds 0x12345678; write wstrb 0x2, wdata 0x0000AB00; read 0x20 → rdata 0x1234AB78. Then read 0x23 (low bits ignored) → same value.
- LATENCY=3, DEPTH=2, req held high for 4 reads of 0x0/0x4/0x8/0xC preloaded 1/2/3/4 → addr_ok is high on 2 cycles, low until the first data_ok, then one accept per retire; data_ok returns 1, 2, 3, 4 in order with no reordering.
- Issue 2 reads, then assert hold for 5 cycles with req high → addr_ok = 0 throughout; both pending data_ok pulses still occur at acceptance+LATENCY; the next request is accepted in the first cycle after hold falls.
- Accept 2 reads, then pull resetn low for 1 cycle before either returns → no data_ok ever appears for them; after reset, a read of a previously written word returns its old value.
- MEM_AW=12: write 0xDEADBEEF to 0x4000, then read 0x0 → 0xDEADBEEF (alias).
